wb_port_arbiter: RTL and testbench
==================================

# wb_port_arbiter

Shares the register file's single write port between the in-order pipeline writeback stage and the long-latency multiply/divide unit (MDU). Grants one writer per cycle and back-pressures the loser. Keeps a busy scoreboard of registers with MDU results still outstanding, and raises a decode-stage hazard stall from it. Sits between the WB stage / MDU and the register file write port.

## Interface
- DATA_W, 32, write data width
- ADDR_W, 5, register address width
- NREGS, 32, number of architectural registers (2**ADDR_W)
- MAX_WAIT, 4, consecutive MDU denials before forced grant (≥1)

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset, asynchronous, active-high
- i_clk_enable  in  1  global stall; low freezes all state
- i_pipe_valid  in  1  pipeline WB has a result
- i_pipe_rd  in  ADDR_W  pipeline destination
- i_pipe_data  in  DATA_W  pipeline result
- o_pipe_stall  out  1  pipeline WB not accepted; WB stage holds
- i_mdu_valid  in  1  MDU result valid; held until accepted
- i_mdu_rd  in  ADDR_W  MDU destination
- i_mdu_data  in  DATA_W  MDU result
- o_mdu_ready  out  1  MDU result accepted when high with i_mdu_valid
- i_issue_valid  in  1  MDU op issued this cycle
- i_issue_rd  in  ADDR_W  destination of issued MDU op
- i_dec_valid  in  1  decode stage holds an instruction
- i_dec_rs1, i_dec_rs2, i_dec_rd  in  ADDR_W each  decode operand/destination addresses
- o_hazard_stall  out  1  decode must stall
- o_reg_write  out  1  register file write enable
- o_wr_addr  out  ADDR_W  register file write address
- o_wr_data  out  DATA_W  register file write data
- o_busy_mask  out  NREGS  scoreboard contents

## Operation
- FSM states: NORMAL, FORCE. Reset: NORMAL, wait_cnt=0, busy mask all zero.
- NORMAL: pipeline has priority.
  - o_mdu_ready = i_clk_enable & !i_pipe_valid.
  - o_pipe_stall = 0.
- FORCE: MDU has priority.
  - o_mdu_ready = i_clk_enable.
  - o_pipe_stall = i_pipe_valid & i_mdu_valid.
  - If i_mdu_valid is low, the pipeline is granted normally.
- o_mdu_ready does not depend on i_mdu_valid.
- Winner drives o_wr_addr/o_wr_data. With no grant: o_wr_addr=0, o_wr_data=0.
- o_reg_write = i_clk_enable & grant & (granted rd != 0). x0 writes are accepted and consumed but not written.
- Starvation counter, advanced only when i_clk_enable=1:
  - In NORMAL, each cycle with i_mdu_valid & !o_mdu_ready increments wait_cnt.
  - When a denial occurs with wait_cnt==MAX_WAIT-1: next state FORCE, wait_cnt=0.
  - Any MDU accept clears wait_cnt.
- FORCE → NORMAL after one cycle, granted or not.
- Scoreboard, updated only when i_clk_enable=1:
  - i_issue_valid & i_issue_rd!=0 sets busy[i_issue_rd].
  - MDU accept clears busy[i_mdu_rd].
  - Set and clear of the same register in one cycle: set wins.
  - Bit 0 is never set.
- o_hazard_stall = i_dec_valid & (busy[rs1] | busy[rs2] | busy[rd]); busy[0] reads 0. The rd term prevents WAW against an outstanding MDU result.
- Reset mid-operation clears FSM, counter and scoreboard. Outstanding MDU results are discarded by the MDU's own reset.

## Timing
- Grant, stall, hazard and write-port outputs are combinational from inputs and registered state. The register file commits at the next i_clk edge, so write latency is 0 cycles.
- FSM, wait_cnt and busy mask are registered; an issue or accept becomes visible in o_busy_mask and o_hazard_stall the following cycle.
- Worst-case MDU wait under continuous pipeline writes is MAX_WAIT+1 cycles.
- i_clk_enable low:
  - no state update;
  - o_reg_write=0, o_mdu_ready=0;
  - o_pipe_stall and o_hazard_stall still evaluated.

## Configuration
- WB_ARB_STARVE_GUARD_EN defined: wait_cnt and the FORCE state are present, as above.
- Undefined: strict pipeline priority. No counter, FSM constant NORMAL, o_pipe_stall tied 0. The MDU can starve indefinitely.

## Structure
- Shared package `wb_arb_pkg`: FSM state encoding (NORMAL=1'b0, FORCE=1'b1), default MAX_WAIT, counter width $clog2(MAX_WAIT+1).
- Sub-module `wb_scoreboard`: busy mask set/clear logic plus three-address hazard lookup. The top holds the FSM and write-port mux.

## Test plan
- Pipeline only, rd=5, data=0xDEADBEEF → o_reg_write=1, addr=5, data=0xDEADBEEF same cycle; o_pipe_stall=0.
- Both valid with MAX_WAIT=4, pipeline continuous → MDU denied 4 cycles. Cycle 5: FSM in FORCE, MDU granted, o_pipe_stall=1. Cycle 6: NORMAL, pipeline granted.
- Issue rd=7, then decode rs1=7 → o_hazard_stall=1 from the next cycle until the MDU accept of rd=7 clears busy[7] at that edge.
- Issue rd=3 in the same cycle the MDU writes rd=3 → busy[3] remains 1.
- Pipeline write to rd=0 and issue rd=0 → o_reg_write=0; busy mask unchanged; accept still consumed.
- Async reset asserted mid-FORCE with busy=0x80 → state NORMAL, wait_cnt=0, o_busy_mask=0 immediately, without a clock edge.

Source files
------------

// File: rtl/wb_arb_pkg.sv
// Shared definitions for the register-file write-port arbiter: FSM encoding,
// default starvation limit and the wait-counter width helper.
package wb_arb_pkg;

  typedef enum logic {
    ST_NORMAL = 1'b0,
    ST_FORCE  = 1'b1
  } arb_state_t;

  localparam int MAX_WAIT_DEFAULT = 4;

  function automatic int cnt_width(input int max_wait);
    return $clog2(max_wait + 1);
  endfunction

endpackage

// File: rtl/wb_scoreboard.sv
// Busy scoreboard of registers with outstanding MDU results, plus the
// three-address decode hazard lookup. x0 is never marked busy.
module wb_scoreboard
  import wb_arb_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int NREGS  = 32
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_clk_enable,
  input  logic              i_set_valid,
  input  logic [ADDR_W-1:0] i_set_rd,
  input  logic              i_clr_valid,
  input  logic [ADDR_W-1:0] i_clr_rd,
  input  logic              i_dec_valid,
  input  logic [ADDR_W-1:0] i_dec_rs1,
  input  logic [ADDR_W-1:0] i_dec_rs2,
  input  logic [ADDR_W-1:0] i_dec_rd,
  output logic              o_hazard_stall,
  output logic [NREGS-1:0]  o_busy_mask
);

  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_nxt;

  // Clear is applied first so a same-cycle issue to that register wins.
  always_comb begin
    busy_nxt = busy_q;
    if (i_clr_valid) busy_nxt[i_clr_rd] = 1'b0;
    if (i_set_valid && (i_set_rd != '0)) busy_nxt[i_set_rd] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      busy_q <= '0;
    end else if (i_clk_enable) begin
      busy_q <= busy_nxt;
    end
  end

  assign o_hazard_stall = i_dec_valid &
                          (busy_q[i_dec_rs1] | busy_q[i_dec_rs2] | busy_q[i_dec_rd]);
  assign o_busy_mask    = busy_q;

endmodule

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter between the WB stage and the MDU.
// Define WB_ARB_STARVE_GUARD_EN to add the MDU starvation guard (wait counter + FORCE state).
//
// state     | meaning
// ST_NORMAL | pipeline has priority, MDU denials are counted
// ST_FORCE  | one cycle of MDU priority after MAX_WAIT consecutive denials
module wb_port_arbiter
  import wb_arb_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NREGS    = 32,
  parameter int MAX_WAIT = MAX_WAIT_DEFAULT
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_clk_enable,
  input  logic              i_pipe_valid,
  input  logic [ADDR_W-1:0] i_pipe_rd,
  input  logic [DATA_W-1:0] i_pipe_data,
  output logic              o_pipe_stall,
  input  logic              i_mdu_valid,
  input  logic [ADDR_W-1:0] i_mdu_rd,
  input  logic [DATA_W-1:0] i_mdu_data,
  output logic              o_mdu_ready,
  input  logic              i_issue_valid,
  input  logic [ADDR_W-1:0] i_issue_rd,
  input  logic              i_dec_valid,
  input  logic [ADDR_W-1:0] i_dec_rs1,
  input  logic [ADDR_W-1:0] i_dec_rs2,
  input  logic [ADDR_W-1:0] i_dec_rd,
  output logic              o_hazard_stall,
  output logic              o_reg_write,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic [DATA_W-1:0] o_wr_data,
  output logic [NREGS-1:0]  o_busy_mask
);

  logic force_mode;
  logic mdu_ready;
  logic mdu_grant;
  logic pipe_stall;
  logic pipe_grant;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

`ifdef WB_ARB_STARVE_GUARD_EN
  localparam int CNT_W = cnt_width(MAX_WAIT);

  arb_state_t       state_q;
  logic [CNT_W-1:0] wait_cnt_q;
  logic             mdu_denied;

  assign force_mode = (state_q == ST_FORCE);
  assign mdu_denied = i_mdu_valid & ~mdu_ready;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= ST_NORMAL;
      wait_cnt_q <= '0;
    end else if (i_clk_enable) begin
      case (state_q)
        ST_NORMAL: begin
          if (mdu_grant) begin
            wait_cnt_q <= '0;
          end else if (mdu_denied) begin
            if (wait_cnt_q == CNT_W'(MAX_WAIT - 1)) begin
              state_q    <= ST_FORCE;
              wait_cnt_q <= '0;
            end else begin
              wait_cnt_q <= wait_cnt_q + CNT_W'(1);
            end
          end
        end
        ST_FORCE: begin
          state_q    <= ST_NORMAL;
          wait_cnt_q <= '0;
        end
        default: begin
          state_q    <= ST_NORMAL;
          wait_cnt_q <= '0;
        end
      endcase
    end
  end
`else
  // Strict pipeline priority: the MDU only gets the port on idle WB cycles.
  assign force_mode = 1'b0;
`endif

  assign mdu_ready  = i_clk_enable & (force_mode | ~i_pipe_valid);
  assign mdu_grant  = mdu_ready & i_mdu_valid;
  assign pipe_stall = force_mode & i_pipe_valid & i_mdu_valid;
  assign pipe_grant = i_pipe_valid & ~pipe_stall;

  always_comb begin
    wr_addr = '0;
    wr_data = '0;
    if (mdu_grant) begin
      wr_addr = i_mdu_rd;
      wr_data = i_mdu_data;
    end else if (pipe_grant) begin
      wr_addr = i_pipe_rd;
      wr_data = i_pipe_data;
    end
  end

  // x0 writes are still granted (and consumed) but never reach the file.
  assign o_reg_write  = i_clk_enable & (mdu_grant | pipe_grant) & (wr_addr != '0);
  assign o_wr_addr    = wr_addr;
  assign o_wr_data    = wr_data;
  assign o_mdu_ready  = mdu_ready;
  assign o_pipe_stall = pipe_stall;

  wb_scoreboard #(
    .ADDR_W (ADDR_W),
    .NREGS  (NREGS)
  ) u_scoreboard (
    .i_clk          (i_clk),
    .i_rst          (i_rst),
    .i_clk_enable   (i_clk_enable),
    .i_set_valid    (i_issue_valid),
    .i_set_rd       (i_issue_rd),
    .i_clr_valid    (mdu_grant),
    .i_clr_rd       (i_mdu_rd),
    .i_dec_valid    (i_dec_valid),
    .i_dec_rs1      (i_dec_rs1),
    .i_dec_rs2      (i_dec_rs2),
    .i_dec_rd       (i_dec_rd),
    .o_hazard_stall (o_hazard_stall),
    .o_busy_mask    (o_busy_mask)
  );

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: expected register-file writes are queued
// when stimulus is driven and popped when the write port is observed.
module tb_wb_port_arbiter;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int NREGS    = 32;
  localparam int MAX_WAIT = 4;

  logic              i_clk;
  logic              i_rst;
  logic              i_clk_enable;
  logic              i_pipe_valid;
  logic [ADDR_W-1:0] i_pipe_rd;
  logic [DATA_W-1:0] i_pipe_data;
  logic              o_pipe_stall;
  logic              i_mdu_valid;
  logic [ADDR_W-1:0] i_mdu_rd;
  logic [DATA_W-1:0] i_mdu_data;
  logic              o_mdu_ready;
  logic              i_issue_valid;
  logic [ADDR_W-1:0] i_issue_rd;
  logic              i_dec_valid;
  logic [ADDR_W-1:0] i_dec_rs1;
  logic [ADDR_W-1:0] i_dec_rs2;
  logic [ADDR_W-1:0] i_dec_rd;
  logic              o_hazard_stall;
  logic              o_reg_write;
  logic [ADDR_W-1:0] o_wr_addr;
  logic [DATA_W-1:0] o_wr_data;
  logic [NREGS-1:0]  o_busy_mask;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  checks = 0;
  int  errors = 0;

  wb_port_arbiter #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .NREGS    (NREGS),
    .MAX_WAIT (MAX_WAIT)
  ) dut (
    .i_clk          (i_clk),
    .i_rst          (i_rst),
    .i_clk_enable   (i_clk_enable),
    .i_pipe_valid   (i_pipe_valid),
    .i_pipe_rd      (i_pipe_rd),
    .i_pipe_data    (i_pipe_data),
    .o_pipe_stall   (o_pipe_stall),
    .i_mdu_valid    (i_mdu_valid),
    .i_mdu_rd       (i_mdu_rd),
    .i_mdu_data     (i_mdu_data),
    .o_mdu_ready    (o_mdu_ready),
    .i_issue_valid  (i_issue_valid),
    .i_issue_rd     (i_issue_rd),
    .i_dec_valid    (i_dec_valid),
    .i_dec_rs1      (i_dec_rs1),
    .i_dec_rs2      (i_dec_rs2),
    .i_dec_rd       (i_dec_rd),
    .o_hazard_stall (o_hazard_stall),
    .o_reg_write    (o_reg_write),
    .o_wr_addr      (o_wr_addr),
    .o_wr_data      (o_wr_data),
    .o_busy_mask    (o_busy_mask)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One queued expectation is consumed per cycle; an empty queue means no write.
  task automatic wr_check(input string tag);
    wr_t e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk({tag, "_we"},   64'(o_reg_write), 64'd1);
      chk({tag, "_addr"}, 64'(o_wr_addr),   64'(e.addr));
      chk({tag, "_data"}, 64'(o_wr_data),   64'(e.data));
    end else begin
      chk({tag, "_we"}, 64'(o_reg_write), 64'd0);
    end
  endtask

  task automatic cyc();
    @(posedge i_clk);
    #1;
  endtask

  initial begin
    i_rst = 1'b1;
    i_clk_enable = 1'b1;
    i_pipe_valid = 1'b0; i_pipe_rd = '0; i_pipe_data = '0;
    i_mdu_valid = 1'b0;  i_mdu_rd = '0;  i_mdu_data = '0;
    i_issue_valid = 1'b0; i_issue_rd = '0;
    i_dec_valid = 1'b0; i_dec_rs1 = '0; i_dec_rs2 = '0; i_dec_rd = '0;
    #2;
    chk("rst_busy",   64'(o_busy_mask),    64'd0);
    chk("rst_we",     64'(o_reg_write),    64'd0);
    chk("rst_pstall", 64'(o_pipe_stall),   64'd0);
    chk("rst_hazard", 64'(o_hazard_stall), 64'd0);
    @(posedge i_clk);
    @(posedge i_clk);
    #1 i_rst = 1'b0;

    // Pipeline-only write.
    cyc();
    i_pipe_valid = 1'b1; i_pipe_rd = 5'd5; i_pipe_data = 32'hDEADBEEF;
    exp_q.push_back('{5'd5, 32'hDEADBEEF});
    #1;
    wr_check("pipe5");
    chk("pipe5_pstall", 64'(o_pipe_stall), 64'd0);
    chk("pipe5_mready", 64'(o_mdu_ready),  64'd0);

    // MDU on an idle WB cycle.
    cyc();
    i_pipe_valid = 1'b0;
    i_mdu_valid = 1'b1; i_mdu_rd = 5'd9; i_mdu_data = 32'h12345678;
    exp_q.push_back('{5'd9, 32'h12345678});
    #1;
    wr_check("mdu9");
    chk("mdu9_mready", 64'(o_mdu_ready), 64'd1);

    // Clock enable low: no write, no ready, issue ignored.
    cyc();
    i_mdu_valid = 1'b0;
    i_clk_enable = 1'b0;
    i_pipe_valid = 1'b1; i_pipe_rd = 5'd6; i_pipe_data = 32'h1;
    i_issue_valid = 1'b1; i_issue_rd = 5'd7;
    #1;
    wr_check("cen_low");
    chk("cen_low_mready", 64'(o_mdu_ready), 64'd0);

    // Issue rd=7; busy only becomes visible next cycle.
    cyc();
    i_clk_enable = 1'b1;
    i_pipe_valid = 1'b0;
    i_issue_valid = 1'b1; i_issue_rd = 5'd7;
    i_dec_valid = 1'b1; i_dec_rs1 = 5'd7; i_dec_rs2 = 5'd0; i_dec_rd = 5'd1;
    #1;
    chk("issue7_busy_now", 64'(o_busy_mask),    64'd0);
    chk("issue7_haz_now",  64'(o_hazard_stall), 64'd0);

    cyc();
    i_issue_valid = 1'b0;
    #1;
    chk("issue7_busy", 64'(o_busy_mask),    64'h80);
    chk("haz_rs1",     64'(o_hazard_stall), 64'd1);
    i_dec_rs1 = 5'd0; i_dec_rs2 = 5'd7;
    #1 chk("haz_rs2", 64'(o_hazard_stall), 64'd1);
    i_dec_rs2 = 5'd0; i_dec_rd = 5'd7;
    #1 chk("haz_rd", 64'(o_hazard_stall), 64'd1);
    i_dec_valid = 1'b0;
    #1 chk("haz_novalid", 64'(o_hazard_stall), 64'd0);
    i_dec_valid = 1'b1; i_dec_rd = 5'd2;
    #1 chk("haz_clear_regs", 64'(o_hazard_stall), 64'd0);

    // Issue rd=3, then issue rd=3 again while the MDU writes rd=3.
    cyc();
    i_issue_valid = 1'b1; i_issue_rd = 5'd3;
    #1;
    cyc();
    i_mdu_valid = 1'b1; i_mdu_rd = 5'd3; i_mdu_data = 32'hAAAA0003;
    exp_q.push_back('{5'd3, 32'hAAAA0003});
    #1;
    wr_check("mdu3_setclr");
    chk("mdu3_mready", 64'(o_mdu_ready), 64'd1);

    // MDU accepts rd=7; hazard holds until the edge.
    cyc();
    i_issue_valid = 1'b0;
    i_mdu_rd = 5'd7; i_mdu_data = 32'h00007777;
    exp_q.push_back('{5'd7, 32'h00007777});
    i_dec_rs1 = 5'd7;
    #1;
    chk("set_wins_busy", 64'(o_busy_mask),    64'h88);
    chk("haz_until_acc", 64'(o_hazard_stall), 64'd1);
    wr_check("mdu7");

    cyc();
    i_mdu_valid = 1'b0;
    #1;
    chk("clr7_busy", 64'(o_busy_mask),    64'h08);
    chk("clr7_haz",  64'(o_hazard_stall), 64'd0);

    // x0 traffic: pipeline write and issue to rd=0.
    cyc();
    i_dec_valid = 1'b0;
    i_pipe_valid = 1'b1; i_pipe_rd = 5'd0; i_pipe_data = 32'h55;
    i_issue_valid = 1'b1; i_issue_rd = 5'd0;
    #1;
    wr_check("pipe_x0");
    chk("pipe_x0_pstall", 64'(o_pipe_stall), 64'd0);

    cyc();
    i_pipe_valid = 1'b0;
    i_issue_valid = 1'b0;
    i_mdu_valid = 1'b1; i_mdu_rd = 5'd0; i_mdu_data = 32'h66;
    #1;
    chk("mdu_x0_mready", 64'(o_mdu_ready), 64'd1);
    wr_check("mdu_x0");
    chk("x0_issue_busy", 64'(o_busy_mask), 64'h08);

    cyc();
    i_mdu_valid = 1'b0;
    #1;
    chk("x0_busy_after", 64'(o_busy_mask), 64'h08);

    // Continuous pipeline writes against a waiting MDU result for rd=3.
    // One frozen cycle (clock enable low) must not advance the wait count.
`ifdef WB_ARB_STARVE_GUARD_EN
    for (int k = 0; k < 5; k++) begin
`else
    for (int k = 0; k < 7; k++) begin
`endif
      cyc();
      i_clk_enable = (k != 2);
      i_pipe_valid = 1'b1; i_pipe_rd = ADDR_W'(10 + k); i_pipe_data = 32'h1000 + k;
      i_mdu_valid = 1'b1; i_mdu_rd = 5'd3; i_mdu_data = 32'hBEEF0003;
      if (k != 2) exp_q.push_back('{ADDR_W'(10 + k), 32'h1000 + k});
      #1;
      wr_check($sformatf("starve%0d", k));
      chk($sformatf("starve%0d_mready", k), 64'(o_mdu_ready),  64'd0);
      chk($sformatf("starve%0d_pstall", k), 64'(o_pipe_stall), 64'd0);
    end
    i_clk_enable = 1'b1;
`ifdef WB_ARB_STARVE_GUARD_EN
    cyc();
    i_pipe_rd = 5'd15; i_pipe_data = 32'h100F;
    exp_q.push_back('{5'd3, 32'hBEEF0003});
    #1;
    wr_check("force");
    chk("force_mready", 64'(o_mdu_ready),  64'd1);
    chk("force_pstall", 64'(o_pipe_stall), 64'd1);

    cyc();
    i_mdu_valid = 1'b0;
    exp_q.push_back('{5'd15, 32'h100F});
    #1;
    wr_check("after_force");
    chk("after_force_pstall", 64'(o_pipe_stall), 64'd0);
    chk("after_force_mready", 64'(o_mdu_ready),  64'd0);
`else
    cyc();
    i_pipe_valid = 1'b0;
    exp_q.push_back('{5'd3, 32'hBEEF0003});
    #1;
    wr_check("mdu3_idle");
    chk("mdu3_idle_mready", 64'(o_mdu_ready), 64'd1);
`endif

    cyc();
    i_pipe_valid = 1'b0; i_mdu_valid = 1'b0;
    #1;
    chk("starve_busy_clr", 64'(o_busy_mask), 64'd0);

    // Async reset while busy=0x80 (and, with the guard, while in FORCE).
    cyc();
    i_issue_valid = 1'b1; i_issue_rd = 5'd7;
    #1;
    cyc();
    i_issue_valid = 1'b0;
    i_pipe_valid = 1'b1; i_pipe_rd = 5'd20; i_pipe_data = 32'h2020;
    i_mdu_valid = 1'b1; i_mdu_rd = 5'd4; i_mdu_data = 32'h4444;
    exp_q.push_back('{5'd20, 32'h2020});
    #1;
    chk("prerst_busy", 64'(o_busy_mask), 64'h80);
    wr_check("prerst0");
`ifdef WB_ARB_STARVE_GUARD_EN
    for (int k = 1; k < MAX_WAIT; k++) begin
      cyc();
      exp_q.push_back('{5'd20, 32'h2020});
      #1;
      wr_check($sformatf("prerst%0d", k));
    end
    cyc();
    exp_q.push_back('{5'd4, 32'h4444});
    #1;
    wr_check("prerst_force");
    chk("prerst_force_pstall", 64'(o_pipe_stall), 64'd1);
`endif
    #1 i_rst = 1'b1;
    #1;
    chk("async_rst_busy",   64'(o_busy_mask),  64'd0);
    chk("async_rst_pstall", 64'(o_pipe_stall), 64'd0);
    chk("async_rst_mready", 64'(o_mdu_ready),  64'd0);
    @(posedge i_clk);
    #1 i_rst = 1'b0;

    // Counter restarts from zero: MAX_WAIT-1 denials must not force.
    for (int k = 0; k < MAX_WAIT - 1; k++) begin
      cyc();
      exp_q.push_back('{5'd20, 32'h2020});
      #1;
      wr_check($sformatf("postrst%0d", k));
      chk($sformatf("postrst%0d_mready", k), 64'(o_mdu_ready),  64'd0);
      chk($sformatf("postrst%0d_pstall", k), 64'(o_pipe_stall), 64'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
